// File: rtl/cpu_sequencer_if.sv
// Memory handshake bundle between the sequencer and the instruction/data memories.
// Latency: none, wires only.
// Backpressure: each request is held by the master until the slave returns its ack.
interface cpu_sequencer_if;
  logic imem_req;
  logic imem_ack;
  logic dmem_req;
  logic dmem_we;
  logic dmem_ack;

  modport master (
    output imem_req,
    output dmem_req,
    output dmem_we,
    input  imem_ack,
    input  dmem_ack
  );

  modport slave (
    input  imem_req,
    input  dmem_req,
    input  dmem_we,
    output imem_ack,
    output dmem_ack
  );
endinterface

// File: rtl/cpu_sequencer.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer that drives strobes for the CPU datapath.
// Latency: BEQ/JUMP/TLBWRITE 3 cycles, ALU 4, store 4, load 5, MUL 3+MUL_CYCLES (zero-wait acks).
// Backpressure: waits in FETCH/MEM until imem_ack/dmem_ack; optional SEQ_IRQ_EN adds TRAP/IRET.
module cpu_sequencer #(
  parameter int MUL_CYCLES = 4,  // 1..15, EXEC cycles spent on MUL
  parameter int CNT_W      = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [5:0]           opcode,
  input  logic                 alu_zero,
  input  logic                 irq,
  cpu_sequencer_if.master      mem,
  output logic                 ir_load,
  output logic                 pc_inc,
  output logic                 pc_load,
  output logic                 rf_we,
  output logic                 tlb_we,
  output logic                 illegal,
  output logic [CNT_W-1:0]     retired,
  output logic [2:0]           state
);

  typedef enum logic [2:0] {
    S_RESET  = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
`ifdef SEQ_IRQ_EN
    S_WB     = 3'd5,
    S_TRAP   = 3'd6
`else
    S_WB     = 3'd5
`endif
  } state_e;

  typedef enum logic [3:0] {
    C_R, C_MUL, C_LOAD, C_STORE, C_MOV, C_BEQ, C_JUMP, C_TLB, C_IRET, C_ILL
  } cls_e;

  // MUL holds EXEC until the counter, loaded with MUL_CYCLES-1, reaches zero.
  localparam logic [3:0] MUL_INIT = 4'(MUL_CYCLES - 1);

  state_e           state_q, state_d;
  cls_e             cls_q, cls_d;
  logic [3:0]       mul_cnt_q, mul_cnt_d;
  logic [CNT_W-1:0] retired_q, retired_d;
  cls_e             op_cls;
  logic             retire;
  logic             imem_req_c, dmem_req_c, dmem_we_c;

`ifdef SEQ_IRQ_EN
  logic ie_q, ie_d;
`else
  logic unused_irq;
  assign unused_irq = irq;
`endif

  function automatic cls_e decode_op(input logic [5:0] op);
    cls_e c;
    case (op)
      6'd0, 6'd1, 6'd3, 6'd4: c = C_R;
      6'd2:                   c = C_MUL;
      6'd10, 6'd11:           c = C_LOAD;
      6'd12, 6'd13:           c = C_STORE;
      6'd14:                  c = C_MOV;
      6'd20:                  c = C_BEQ;
      6'd21:                  c = C_JUMP;
      6'd30:                  c = C_TLB;
      6'd31:                  c = C_IRET;
      default:                c = C_ILL;
    endcase
    return c;
  endfunction

  assign op_cls = decode_op(opcode);

  // Next-state and strobe generation; strobes are Moore outputs of the state plus ack.
  always_comb begin
    state_d    = state_q;
    cls_d      = cls_q;
    mul_cnt_d  = mul_cnt_q;
`ifdef SEQ_IRQ_EN
    ie_d       = ie_q;
`endif
    imem_req_c = 1'b0;
    dmem_req_c = 1'b0;
    dmem_we_c  = 1'b0;
    ir_load    = 1'b0;
    pc_inc     = 1'b0;
    pc_load    = 1'b0;
    rf_we      = 1'b0;
    tlb_we     = 1'b0;
    illegal    = 1'b0;
    retire     = 1'b0;

    case (state_q)
      S_RESET: state_d = S_FETCH;

      S_FETCH: begin
        imem_req_c = 1'b1;
        if (mem.imem_ack) begin
          ir_load = 1'b1;
          state_d = S_DECODE;
        end
      end

      S_DECODE: begin
        pc_inc    = 1'b1;
        cls_d     = op_cls;
        mul_cnt_d = MUL_INIT;
        if (op_cls == C_ILL) begin
          illegal = 1'b1;
          state_d = S_FETCH;
        end else begin
          state_d = S_EXEC;
        end
      end

      S_EXEC: begin
        case (cls_q)
          C_R, C_MOV: state_d = S_WB;
          C_MUL: begin
            if (mul_cnt_q == 4'd0) state_d = S_WB;
            else mul_cnt_d = mul_cnt_q - 4'd1;
          end
          C_LOAD, C_STORE: state_d = S_MEM;
          C_BEQ: begin
            pc_load = alu_zero;
            retire  = 1'b1;
            state_d = S_FETCH;
          end
          C_JUMP: begin
            pc_load = 1'b1;
            retire  = 1'b1;
            state_d = S_FETCH;
          end
          C_TLB: begin
            tlb_we  = 1'b1;
            retire  = 1'b1;
            state_d = S_FETCH;
          end
          C_IRET: begin
`ifdef SEQ_IRQ_EN
            pc_load = 1'b1;
            ie_d    = 1'b1;
`endif
            retire  = 1'b1;
            state_d = S_FETCH;
          end
          default: state_d = S_FETCH;
        endcase
      end

      S_MEM: begin
        dmem_req_c = 1'b1;
        dmem_we_c  = (cls_q == C_STORE);
        if (mem.dmem_ack) begin
          if (cls_q == C_STORE) begin
            retire  = 1'b1;
            state_d = S_FETCH;
          end else begin
            state_d = S_WB;
          end
        end
      end

      S_WB: begin
        rf_we   = 1'b1;
        retire  = 1'b1;
        state_d = S_FETCH;
      end

`ifdef SEQ_IRQ_EN
      S_TRAP: begin
        pc_load = 1'b1;
        ie_d    = 1'b0;
        state_d = S_FETCH;
      end
`endif

      default: state_d = S_FETCH;
    endcase

`ifdef SEQ_IRQ_EN
    // An enabled interrupt diverts the retiring instruction's successor into TRAP.
    if (retire && irq && ie_q) state_d = S_TRAP;
`endif

    retired_d = retired_q + CNT_W'(retire);
  end

  // State registers; async reset drops every request immediately via S_RESET.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_RESET;
      cls_q     <= C_R;
      mul_cnt_q <= 4'd0;
      retired_q <= '0;
`ifdef SEQ_IRQ_EN
      ie_q      <= 1'b1;
`endif
    end else begin
      state_q   <= state_d;
      cls_q     <= cls_d;
      mul_cnt_q <= mul_cnt_d;
      retired_q <= retired_d;
`ifdef SEQ_IRQ_EN
      ie_q      <= ie_d;
`endif
    end
  end

  assign mem.imem_req = imem_req_c;
  assign mem.dmem_req = dmem_req_c;
  assign mem.dmem_we  = dmem_we_c;
  assign retired      = retired_q;
  assign state        = state_q;

endmodule

// File: tb/tb_cpu_sequencer.sv
// Directed bench for cpu_sequencer: table of instructions with hand-computed strobe timing,
// plus hand-written sequences for reset, async reset mid-MEM and the optional interrupt path.
// All DUT outputs are sampled 1 time unit after the falling edge.
module tb_cpu_sequencer;

  localparam logic [2:0] ST_RESET = 3'd0;
  localparam logic [2:0] ST_FETCH = 3'd1;
  localparam logic [2:0] ST_MEM   = 3'd4;
  localparam logic [2:0] ST_TRAP  = 3'd6;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  opcode;
  logic        alu_zero;
  logic        irq;
  logic        ir_load, pc_inc, pc_load, rf_we, tlb_we, illegal;
  logic [31:0] retired;
  logic [2:0]  state;

  cpu_sequencer_if bus ();

  cpu_sequencer #(.MUL_CYCLES(4), .CNT_W(32)) dut (
    .clk      (clk),
    .rst      (rst),
    .opcode   (opcode),
    .alu_zero (alu_zero),
    .irq      (irq),
    .mem      (bus),
    .ir_load  (ir_load),
    .pc_inc   (pc_inc),
    .pc_load  (pc_load),
    .rf_we    (rf_we),
    .tlb_we   (tlb_we),
    .illegal  (illegal),
    .retired  (retired),
    .state    (state)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // One instruction: stimulus plus expected per-instruction totals (cycle indices are 1-based).
  typedef struct {
    logic [5:0] op;
    logic       az;
    int         id;       // imem_ack delay in cycles of imem_req
    int         dd;       // dmem_ack delay in cycles of dmem_req
    logic       stray;    // drive acks high while the matching req is low
    logic [5:0] op_late;  // opcode driven from EXEC onwards
    int         cyc;
    int         imreq;
    int         dmreq;
    int         dmwe;
    int         rfwe_at;  // 0 = no rf_we
    int         pcload;
    int         tlb;
    int         ill;
    int         ret;
  } vec_t;

  typedef struct {
    int cyc, imreq, irload_cnt, irload_at, pcinc_at, dmreq, dmwe;
    int rfwe_cnt, rfwe_at, pcload, tlb, ill, ret;
    logic done;
  } meas_t;

  // Must be called just after a falling edge with the DUT in FETCH.
  task automatic run_instr(input vec_t v, output meas_t m);
    logic left;
    logic [31:0] ret0;
    m = '{default: 0};
    left = 1'b0;
    ret0 = retired;
    for (int i = 0; i < 64 && !m.done; i++) begin
      opcode   = (state == ST_FETCH || state == 3'd2) ? v.op : v.op_late;
      alu_zero = v.az;
      bus.imem_ack = bus.imem_req ? (m.imreq >= v.id) : v.stray;
      bus.dmem_ack = bus.dmem_req ? (m.dmreq >= v.dd) : v.stray;
      #1;
      m.cyc++;
      if (bus.imem_req) m.imreq++;
      if (bus.dmem_req) m.dmreq++;
      if (bus.dmem_req && bus.dmem_we) m.dmwe++;
      if (ir_load) begin m.irload_cnt++; m.irload_at = m.cyc; end
      if (pc_inc) m.pcinc_at = m.cyc;
      if (rf_we) begin m.rfwe_cnt++; m.rfwe_at = m.cyc; end
      if (pc_load) m.pcload++;
      if (tlb_we) m.tlb++;
      if (illegal) m.ill++;
      @(negedge clk);
      if (state != ST_FETCH && state != ST_TRAP) left = 1'b1;
      else if (left || state == ST_TRAP) m.done = 1'b1;
    end
    m.ret = int'(retired - ret0);
    bus.imem_ack = 1'b0;
    bus.dmem_ack = 1'b0;
  endtask

  vec_t  rows [16];
  meas_t m;
  logic  iret_pl;

  initial begin
    #200000;
    $display("FAIL global timeout: got 0, expected 1");
    $fatal(1, "timeout");
  end

  initial begin
`ifdef SEQ_IRQ_EN
    iret_pl = 1'b1;
`else
    iret_pl = 1'b0;
`endif
    //          op  az id dd st late cyc imq dmq dwe rfat pcl tlb ill ret
    rows[0]  = '{6'd0,  0, 0, 0, 0, 6'd0,  4, 1, 0, 0, 4, 0, 0, 0, 1};
    rows[1]  = '{6'd0,  0, 3, 0, 0, 6'd0,  7, 4, 0, 0, 7, 0, 0, 0, 1};
    rows[2]  = '{6'd13, 0, 0, 2, 0, 6'd13, 6, 1, 3, 3, 0, 0, 0, 0, 1};
    rows[3]  = '{6'd20, 1, 0, 0, 0, 6'd20, 3, 1, 0, 0, 0, 1, 0, 0, 1};
    rows[4]  = '{6'd20, 0, 0, 0, 0, 6'd20, 3, 1, 0, 0, 0, 0, 0, 0, 1};
    rows[5]  = '{6'd2,  0, 0, 0, 0, 6'd21, 7, 1, 0, 0, 7, 0, 0, 0, 1};
    rows[6]  = '{6'd7,  0, 0, 0, 0, 6'd7,  2, 1, 0, 0, 0, 0, 0, 1, 0};
    rows[7]  = '{6'd10, 0, 0, 0, 0, 6'd13, 5, 1, 1, 0, 5, 0, 0, 0, 1};
    rows[8]  = '{6'd21, 0, 0, 0, 0, 6'd0,  3, 1, 0, 0, 0, 1, 0, 0, 1};
    rows[9]  = '{6'd30, 0, 0, 0, 0, 6'd0,  3, 1, 0, 0, 0, 0, 1, 0, 1};
    rows[10] = '{6'd31, 0, 0, 0, 0, 6'd0,  3, 1, 0, 0, 0, int'(iret_pl), 0, 0, 1};
    rows[11] = '{6'd14, 0, 0, 0, 0, 6'd12, 4, 1, 0, 0, 4, 0, 0, 0, 1};
    rows[12] = '{6'd12, 0, 1, 1, 1, 6'd10, 6, 2, 2, 2, 0, 0, 0, 0, 1};
    rows[13] = '{6'd63, 0, 0, 0, 0, 6'd0,  2, 1, 0, 0, 0, 0, 0, 1, 0};
    rows[14] = '{6'd4,  0, 0, 0, 1, 6'd30, 4, 1, 0, 0, 4, 0, 0, 0, 1};
    rows[15] = '{6'd11, 1, 2, 1, 0, 6'd21, 8, 3, 2, 0, 8, 0, 0, 0, 1};

    // Reset state, with acks high to show they are ignored.
    rst = 1'b1; opcode = 6'd0; alu_zero = 1'b0; irq = 1'b0;
    bus.imem_ack = 1'b1; bus.dmem_ack = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    check("reset state", state, ST_RESET);
    check("reset reqs", {bus.imem_req, bus.dmem_req, bus.dmem_we}, 0);
    check("reset strobes", {ir_load, pc_inc, pc_load, rf_we, tlb_we, illegal}, 0);
    check("reset retired", retired, 0);
    bus.imem_ack = 1'b0; bus.dmem_ack = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("leave reset", state, ST_FETCH);

    for (int r = 0; r < 16; r++) begin
      run_instr(rows[r], m);
      check($sformatf("row%0d done", r), m.done, 1);
      check($sformatf("row%0d cycles", r), m.cyc, rows[r].cyc);
      check($sformatf("row%0d imem_req", r), m.imreq, rows[r].imreq);
      check($sformatf("row%0d ir_load cnt", r), m.irload_cnt, 1);
      check($sformatf("row%0d ir_load at", r), m.irload_at, rows[r].imreq);
      check($sformatf("row%0d pc_inc at", r), m.pcinc_at, rows[r].imreq + 1);
      check($sformatf("row%0d dmem_req", r), m.dmreq, rows[r].dmreq);
      check($sformatf("row%0d dmem_we", r), m.dmwe, rows[r].dmwe);
      check($sformatf("row%0d rf_we cnt", r), m.rfwe_cnt, (rows[r].rfwe_at != 0) ? 1 : 0);
      check($sformatf("row%0d rf_we at", r), m.rfwe_at, rows[r].rfwe_at);
      check($sformatf("row%0d pc_load", r), m.pcload, rows[r].pcload);
      check($sformatf("row%0d tlb_we", r), m.tlb, rows[r].tlb);
      check($sformatf("row%0d illegal", r), m.ill, rows[r].ill);
      check($sformatf("row%0d retired delta", r), m.ret, rows[r].ret);
      if (r == 0) check("first retired", retired, 1);
    end
    check("table retired total", retired, 14);

    // Async reset while a store waits in MEM.
    opcode = 6'd12;
    for (int k = 0; k < 20 && state != ST_MEM; k++) begin
      bus.imem_ack = (state == ST_FETCH);
      bus.dmem_ack = 1'b0;
      @(negedge clk);
    end
    bus.imem_ack = 1'b0;
    #1;
    check("mid-MEM reached", state, ST_MEM);
    check("mid-MEM req", {bus.dmem_req, bus.dmem_we}, 2'b11);
    #2 rst = 1'b1;
    #1;
    check("async rst dmem_req", {bus.dmem_req, bus.dmem_we}, 0);
    check("async rst state", state, ST_RESET);
    check("async rst retired", retired, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("refetch after rst", state, ST_FETCH);

    // Interrupt behaviour.
    irq = 1'b1;
    run_instr(rows[0], m);
`ifdef SEQ_IRQ_EN
    #1;
    check("irq trap state", state, ST_TRAP);
    check("irq trap pc_load", pc_load, 1);
    @(negedge clk);
    check("trap to fetch", state, ST_FETCH);
    run_instr(rows[0], m);
    check("irq masked", state, ST_FETCH);
    run_instr(rows[10], m);
    check("iret pc_load", m.pcload, 1);
    check("iret to fetch", state, ST_FETCH);
    run_instr(rows[0], m);
    #1;
    check("irq after iret", state, ST_TRAP);
`else
    check("irq ignored", state, ST_FETCH);
    check("irq ignored retire", m.ret, 1);
    check("irq ignored pc_load", m.pcload, 0);
`endif
    irq = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
